// File: rtl/motion_mask.sv
// ============================================================================
// Module      : motion_mask
// Description : Frame-difference threshold followed by 3x3 binary erosion;
//               emits a 0x00/0xFF motion mask with coordinates, 2-clk latency.
//               Optional macro MOTION_CNT_EN builds the per-frame fg_count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module motion_mask #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int DIFF_TH  = 30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        lcd_clken,
  input  logic [10:0] lcd_xpos,
  input  logic [10:0] lcd_ypos,
  input  logic [7:0]  sys_data_out1,
  input  logic [7:0]  sys_data_out2,
  output logic        mask_clken,
  output logic [10:0] mask_xpos,
  output logic [10:0] mask_ypos,
  output logic [7:0]  mask_data,
  output logic [18:0] fg_count
);

  localparam int          C_XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam logic [10:0] C_H  = 11'(H_ACTIVE);
  localparam logic [10:0] C_V  = 11'(V_ACTIVE);
  localparam logic [7:0]  C_TH = 8'(DIFF_TH);

  // ---------------- stage 1: difference and threshold ----------------
  logic [8:0] w_diff;
  logic [7:0] w_mag;
  logic       w_in_range;

  assign w_diff     = {1'b0, sys_data_out1} - {1'b0, sys_data_out2};
  assign w_mag      = w_diff[8] ? 8'(-w_diff) : w_diff[7:0];
  assign w_in_range = (lcd_xpos < C_H) && (lcd_ypos < C_V);

  logic        r_vld;
  logic        r_bin;
  logic        r_inr;
  logic [10:0] r_x;
  logic [10:0] r_y;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld <= 1'b0;
      r_bin <= 1'b0;
      r_inr <= 1'b0;
      r_x   <= '0;
      r_y   <= '0;
    end else begin
      r_vld <= lcd_clken;
      if (lcd_clken) begin
        r_bin <= w_in_range && (w_mag > C_TH);
        r_inr <= w_in_range;
        r_x   <= lcd_xpos;
        r_y   <= lcd_ypos;
      end
    end
  end

  // ---------------- stage 2: line buffers and 3x3 window ----------------
  logic            r_lb1 [H_ACTIVE];
  logic            r_lb2 [H_ACTIVE];
  logic [C_XW-1:0] w_idx;
  logic            w_col_top;
  logic            w_col_mid;

  assign w_idx     = r_x[C_XW-1:0];
  assign w_col_top = r_inr ? r_lb2[w_idx] : 1'b0;
  assign w_col_mid = r_inr ? r_lb1[w_idx] : 1'b0;

  // Storage is left unreset: rows 0/1 of every frame are masked by the border.
  always_ff @(posedge clk) begin
    if (r_vld && r_inr) begin
      r_lb2[w_idx] <= r_lb1[w_idx];
      r_lb1[w_idx] <= r_bin;
    end
  end

  logic [2:0] r_top, r_mid, r_bot;
  logic [2:0] w_top_n, w_mid_n, w_bot_n;
  logic       w_mask_bit;

  assign w_top_n    = {r_top[1:0], w_col_top};
  assign w_mid_n    = {r_mid[1:0], w_col_mid};
  assign w_bot_n    = {r_bot[1:0], r_bin};
  assign w_mask_bit = (&{w_top_n, w_mid_n, w_bot_n}) && r_inr
                      && (r_x >= 11'd2) && (r_y >= 11'd2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_top      <= '0;
      r_mid      <= '0;
      r_bot      <= '0;
      mask_clken <= 1'b0;
      mask_xpos  <= '0;
      mask_ypos  <= '0;
      mask_data  <= '0;
    end else if (r_vld) begin
      r_top      <= w_top_n;
      r_mid      <= w_mid_n;
      r_bot      <= w_bot_n;
      mask_clken <= 1'b1;
      mask_xpos  <= r_x;
      mask_ypos  <= r_y;
      mask_data  <= {8{w_mask_bit}};
    end else begin
      mask_clken <= 1'b0;
      mask_data  <= '0;
    end
  end

  // ---------------- optional foreground counter ----------------
`ifdef MOTION_CNT_EN
  localparam logic [10:0] C_XLAST = 11'(H_ACTIVE - 1);
  localparam logic [10:0] C_YLAST = 11'(V_ACTIVE - 1);

  logic [18:0] r_cnt;
  logic [18:0] w_cnt_base;
  logic [18:0] w_cnt_next;

  assign w_cnt_base = ((r_x == 11'd0) && (r_y == 11'd0)) ? 19'd0 : r_cnt;
  assign w_cnt_next = w_cnt_base + {18'd0, w_mask_bit};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      fg_count <= '0;
    end else if (r_vld) begin
      r_cnt <= w_cnt_next;
      if ((r_x == C_XLAST) && (r_y == C_YLAST)) begin
        fg_count <= w_cnt_next;
      end
    end
  end
`else
  assign fg_count = '0;
`endif

endmodule

`default_nettype wire

// File: doc/motion_mask.md
Name: motion_mask

Overview:
- Upstream neighbour of the box-marking overlay stage. Consumes the LCD-timed pixel stream: current-frame and previous-frame grey values with pixel coordinates.
- Computes the absolute frame difference, thresholds it to a binary motion bit, then applies a 3x3 binary erosion to remove isolated noise.
- Emits an 8-bit mask (0x00/0xFF) plus matching coordinates and enable. The overlay stage uses this mask to track the bounding box.

Parameters:
H_ACTIVE, 640, active pixels per line; line buffer depth
V_ACTIVE, 480, active lines per frame
DIFF_TH, 30, motion threshold; a pixel is foreground when |cur-prev| > DIFF_TH (strict)

Ports:
clk  in  1  pixel clock
rst  in  1  asynchronous, active-high reset
lcd_clken  in  1  pixel-valid strobe
lcd_xpos  in  11  pixel column
lcd_ypos  in  11  pixel row
sys_data_out1  in  8  current-frame grey value
sys_data_out2  in  8  previous-frame grey value
mask_clken  out  1  output pixel valid
mask_xpos  out  11  coordinate accompanying mask_data
mask_ypos  out  11  coordinate accompanying mask_data
mask_data  out  8  0xFF = motion, 0x00 = none
fg_count  out  19  foreground pixel count of the last completed frame

Behaviour:
- Reset values: every output register is 0, and all pipeline and window registers are 0. Line-buffer storage is not reset; gating makes stale contents harmless.
- Interface: one clock domain (clk). rst is asynchronous and active-high.
- Stage 1 (cycle t, lcd_clken=1):
  - d = |sys_data_out1 - sys_data_out2|, computed as a 9-bit subtract followed by a magnitude.
  - bin = (d > DIFF_TH).
  - Register bin, x, y and the valid bit.
  - If lcd_clken=0, the valid bit is registered as 0.
- Stage 2 (cycle t+1, valid=1):
  - Two 1-bit line buffers of depth H_ACTIVE, indexed by x, with asynchronous read.
  - lb1[x] holds row y-1; lb2[x] holds row y-2.
  - Each pixel reads old lb1[x] and old lb2[x], then writes lb2[x]<=lb1[x] and lb1[x]<=bin.
  - The 3x3 window shifts one column left and loads the new column {lb2[x], lb1[x], bin}.
- Output (cycle t+2):
  - mask_clken=1; mask_xpos/mask_ypos = the input x/y from cycle t.
  - mask_data=0xFF iff all 9 window bits are 1, else 0x00.
  - Fixed latency: 2 clk from the input strobe to the output strobe.
- Spatial shift: the mask at (x,y) is the erosion centred on (x-1,y-1). This one-pixel right/down offset is accepted by the downstream box logic.
- Border: mask_data forced 0x00 when x<2 or y<2, because the window is incomplete.
- Out-of-range input (x>=H_ACTIVE or y>=V_ACTIVE) with lcd_clken=1:
  - bin treated as 0, no line-buffer write.
  - Output still strobes, with mask_data 0x00.
- Enable gaps: when valid=0, the pipeline and window hold, mask_clken=0 and mask_data=0x00. Arbitrary lcd_clken duty cycles give results identical to a continuous stream.
- Reset mid-frame: all registers clear immediately. Output is correct from the first pixel of the next frame, and from row 2 onward of any frame started after release.

Optional Feature:
Macro MOTION_CNT_EN
- Defined:
  - A 19-bit counter clears on the output pixel (0,0) and increments on each output with mask_data=0xFF, including a 0xFF at (0,0) itself.
  - On output pixel (H_ACTIVE-1, V_ACTIVE-1), fg_count <= the final count, including that pixel. fg_count holds until the next frame end.
- Not defined: no counter is built and fg_count is tied to 0.

Test Plan:
- Reset: rst=1 mid-stream -> all outputs 0 within the same cycle, asynchronously; after release mask_clken follows lcd_clken by exactly 2 clk.
- Identical frames, cur=prev=100 for the whole 640x480 -> mask_data always 0x00; fg_count=0.
- Block at x 100..109, y 50..59 with cur=200, prev=50, elsewhere equal -> mask 0xFF exactly at x 102..109, y 52..59 (64 pixels); fg_count=64 (MOTION_CNT_EN).
- Isolated single differing pixel at (300,200), and a 2-pixel-wide line -> both fully eroded; mask 0x00 everywhere.
- Threshold edges on a 5x5 block: diff 30 -> 0x00; diff 31 -> centre 0xFF; prev>cur (prev=200, cur=50) -> foreground detected.
- Random lcd_clken gaps (about 50% duty) replaying the block frame -> mask/coordinate sequence identical to the continuous run; no output at gap cycles.
